seg7_hex_counter: RTL and testbench

SEG7_HEX_COUNTER -- requirements
Module: seg7_hex_counter

---
 rtl/seg7_pkg.sv | 23 ++
 rtl/seg7_hex_decode.sv | 13 +
 rtl/seg7_hex_counter.sv | 112 +++++++++++
 tb/tb_seg7_hex_counter.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared definitions for the hex counter: digit type, segment font and
// legal parameter ranges.
package seg7_pkg;

  typedef logic [3:0] digit_t;
  typedef logic [6:0] seg_t;

  localparam int unsigned MODULUS_MIN  = 2;
  localparam int unsigned MODULUS_MAX  = 16;
  localparam int unsigned PRESCALE_MIN = 1;
  localparam int unsigned PRESCALE_MAX = 65535;

  // Active-high segment patterns, A = bit 0, for hex digits 0..F
  localparam seg_t SEG_TABLE [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  function automatic seg_t seg_lookup(input digit_t d);
    return SEG_TABLE[d];
  endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex digit to active-high seven-segment pattern.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] digit_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = seg_lookup(digit_i);
  end

endmodule

// File: rtl/seg7_hex_counter.sv
// Prescaled up/down hex counter with a synchronised step button, display
// hold, blanking and a registered wrap pulse, driving a 7-segment display.
module seg7_hex_counter
  import seg7_pkg::*;
#(
  parameter int unsigned PRESCALE       = 4,
  parameter int unsigned MODULUS        = 16,
  parameter bit          SEG_ACTIVE_LOW = 1'b0
) (
  input  logic [7:0] io_in,
  output logic [7:0] io_out
);

  generate
    if (MODULUS < MODULUS_MIN || MODULUS > MODULUS_MAX) begin : g_bad_modulus
      $error("seg7_hex_counter: MODULUS out of range 2..16");
    end
    if (PRESCALE < PRESCALE_MIN || PRESCALE > PRESCALE_MAX) begin : g_bad_prescale
      $error("seg7_hex_counter: PRESCALE out of range 1..65535");
    end
  endgenerate

  localparam logic [15:0] PRE_LAST = 16'(PRESCALE - 1);
  localparam digit_t      CNT_LAST = digit_t'(MODULUS - 1);

  logic clk, rst, en, up, step, clr, blank, hold;
  assign clk   = io_in[0];
  assign rst   = io_in[1];
  assign en    = io_in[2];
  assign up    = io_in[3];
  assign step  = io_in[4];
  assign clr   = io_in[5];
  assign blank = io_in[6];
  assign hold  = io_in[7];

  logic [15:0] pre_q, pre_d;
  digit_t      cnt_q, cnt_d;
  digit_t      disp_q, disp_d;
  logic        wrap_q, wrap_d;
  logic        sync1_q, sync2_q, sync3_q;
  logic        tick, step_edge, advance;

  always_comb begin
    tick      = en && (pre_q == PRE_LAST);
    step_edge = sync2_q & ~sync3_q;
    advance   = tick | step_edge;
    pre_d     = pre_q;
    cnt_d     = cnt_q;
    wrap_d    = 1'b0;
    disp_d    = hold ? disp_q : cnt_q;
    if (clr) begin
      pre_d = '0;
      cnt_d = '0;
    end else begin
      if (en) begin
        pre_d = tick ? 16'd0 : pre_q + 16'd1;
      end
      // Tick and step edge in the same cycle still advance only once
      if (advance) begin
        if (up) begin
          if (cnt_q == CNT_LAST) begin
            cnt_d  = '0;
            wrap_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end else begin
          if (cnt_q == '0) begin
            cnt_d  = CNT_LAST;
            wrap_d = 1'b1;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
      end
    end
  end

  // Synchroniser flops reset high so a button held through reset is not an edge
  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q   <= '0;
      cnt_q   <= '0;
      disp_q  <= '0;
      wrap_q  <= 1'b0;
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      sync3_q <= 1'b1;
    end else begin
      pre_q   <= pre_d;
      cnt_q   <= cnt_d;
      disp_q  <= disp_d;
      wrap_q  <= wrap_d;
      sync1_q <= step;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  logic [6:0] seg_raw, seg_vis;

  seg7_hex_decode u_decode (
    .digit_i (disp_q),
    .seg_o   (seg_raw)
  );

  always_comb begin
    seg_vis = blank ? 7'h00 : seg_raw;
    io_out  = {wrap_q, (SEG_ACTIVE_LOW ? ~seg_vis : seg_vis)};
  end

endmodule

// File: tb/tb_seg7_hex_counter.sv
// Bench for seg7_hex_counter: two parameterisations share one stimulus and
// are compared every cycle against an arithmetic reference model.
module tb_seg7_hex_counter;

  logic clk = 1'b0;
  logic rst = 1'b1, en = 1'b0, up = 1'b1, step = 1'b0;
  logic clr = 1'b0, blank = 1'b0, hold = 1'b0;
  logic [7:0] in_v;
  logic [7:0] out_a, out_b;

  assign in_v = {hold, blank, clr, step, up, en, rst, clk};

  seg7_hex_counter #(.PRESCALE(4), .MODULUS(16), .SEG_ACTIVE_LOW(1'b0)) u_a (
    .io_in  (in_v),
    .io_out (out_a)
  );

  seg7_hex_counter #(.PRESCALE(3), .MODULUS(10), .SEG_ACTIVE_LOW(1'b1)) u_b (
    .io_in  (in_v),
    .io_out (out_b)
  );

  always #5 clk = ~clk;

  localparam int P_CFG [2]  = '{4, 3};
  localparam int M_CFG [2]  = '{16, 10};
  localparam bit AL_CFG [2] = '{1'b0, 1'b1};

  int checks = 0;
  int errors = 0;
  string phase = "reset";

  logic [6:0] font [16];
  int cnt_m [2];
  int pre_m [2];
  int disp_m [2];
  bit wrap_m [2];
  bit step_s [$];   // step samples, newest first

  initial begin
    font = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  end

  // Reference model: advances one clock edge at a time from the rules
  always @(posedge clk) begin
    bit sedge, tick, adv, w;
    int nd;
    sedge = (step_s.size() >= 3) ? (step_s[1] && !step_s[2]) : 1'b0;
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        cnt_m[i] = 0; pre_m[i] = 0; disp_m[i] = 0; wrap_m[i] = 1'b0;
      end else begin
        tick = en && (pre_m[i] == P_CFG[i] - 1);
        adv  = tick || sedge;
        nd   = hold ? disp_m[i] : cnt_m[i];
        w    = 1'b0;
        if (clr) begin
          cnt_m[i] = 0; pre_m[i] = 0;
        end else begin
          if (en) pre_m[i] = tick ? 0 : pre_m[i] + 1;
          if (adv) begin
            if (up) begin
              w = (cnt_m[i] == M_CFG[i] - 1);
              cnt_m[i] = (cnt_m[i] + 1) % M_CFG[i];
            end else begin
              w = (cnt_m[i] == 0);
              cnt_m[i] = (cnt_m[i] + M_CFG[i] - 1) % M_CFG[i];
            end
          end
        end
        disp_m[i] = nd;
        wrap_m[i] = w;
      end
    end
    if (rst) begin
      step_s = '{1'b1, 1'b1, 1'b1};
    end else begin
      step_s.push_front(step);
      if (step_s.size() > 4) void'(step_s.pop_back());
    end
  end

  function automatic logic [7:0] expect_out(input int i);
    logic [6:0] seg;
    seg = blank ? 7'h00 : font[disp_m[i]];
    if (AL_CFG[i]) seg = ~seg;
    return {wrap_m[i], seg};
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s/%s observed=%h expected=%h", phase, tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
      check("dutA", out_a, expect_out(0));
      check("dutB", out_b, expect_out(1));
    end
  endtask

  task automatic pulse_step();
    step = 1'b1; cycles(2);
    step = 1'b0; cycles(2);
  endtask

  initial begin
    @(negedge clk);
    rst = 1'b1;
    cycles(2);
    check("rst_a_const", out_a, 8'h3F);
    check("rst_b_const", out_b, 8'h40);

    phase = "count_up";
    rst = 1'b0; en = 1'b1; up = 1'b1;
    cycles(14);
    phase = "wrap_up";
    cycles(70);

    phase = "count_down";
    up = 1'b0;
    cycles(40);

    phase = "step_only";
    en = 1'b0; up = 1'b1;
    repeat (3) pulse_step();
    phase = "step_with_tick";
    en = 1'b1;
    repeat (4) pulse_step();

    phase = "hold";
    rst = 1'b1; cycles(1);
    rst = 1'b0; en = 1'b0;
    repeat (5) pulse_step();
    cycles(3);
    hold = 1'b1; en = 1'b1;
    cycles(45);
    blank = 1'b1; cycles(3);
    hold = 1'b0; cycles(2);
    blank = 1'b0; cycles(3);

    phase = "clear";
    clr = 1'b1; cycles(2);
    clr = 1'b0; cycles(6);

    phase = "rst_step_high";
    step = 1'b1; rst = 1'b1; cycles(2);
    rst = 1'b0; cycles(6);
    step = 1'b0; cycles(3);
    step = 1'b1; cycles(4);
    step = 1'b0; cycles(2);

    phase = "random";
    for (int k = 0; k < 800; k++) begin
      rst = ($urandom_range(63) == 0);
      clr = ($urandom_range(31) == 0);
      en  = ($urandom_range(3) != 0);
      if ($urandom_range(15) == 0) up = ~up;
      if ($urandom_range(4) == 0) step = ~step;
      if ($urandom_range(15) == 0) hold = ~hold;
      if ($urandom_range(15) == 0) blank = ~blank;
      cycles(1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
